// File: rtl/iob_uart_fifo.sv
// iob_uart_fifo: memory-mapped UART with TX/RX FIFOs, RTS/CTS flow control,
// sticky error flags and FIFO level readback. 8N1 frames, LSB first.
// Optional feature macro: UART_PARITY_EN adds the parity bit (CTRL bits 3-4,
// STATUS bit 7). Without it frames are always 10 bits.
module iob_uart_fifo #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32,
  parameter int DIV_W  = 16,
  parameter int FIFO_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                txd,
  input  logic                rxd,
  input  logic                cts,
  output logic                rts
);

  localparam int              DEPTH_N = 1 << FIFO_W;
  localparam logic [FIFO_W:0] DEPTH   = {1'b1, {FIFO_W{1'b0}}};
  localparam logic [FIFO_W:0] RTS_LVL = DEPTH - (FIFO_W+1)'(2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  // Bus decode: any strobe bit set means write.
  logic wr, rd, unused_bits;
  assign wr = valid & (|wstrb);
  assign rd = valid & ~(|wstrb);
  assign unused_bits = ^wdata;

  logic soft_rst, txen, rxen, flowen, paren, parodd;
  logic [DIV_W-1:0] div, div_eff, bit_end, half_end;
  assign div_eff  = (div < DIV_W'(2)) ? DIV_W'(2) : div;
  assign bit_end  = div_eff - DIV_W'(1);
  assign half_end = (div_eff >> 1) - DIV_W'(1);

`ifdef UART_PARITY_EN
  logic paren_q, parodd_q;
  assign paren  = paren_q;
  assign parodd = parodd_q;
`else
  assign paren  = 1'b0;
  assign parodd = 1'b0;
`endif

  // Control registers and the one-cycle soft reset pulse.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      soft_rst <= 1'b0;
      div      <= '0;
      txen     <= 1'b0;
      rxen     <= 1'b0;
      flowen   <= 1'b0;
`ifdef UART_PARITY_EN
      paren_q  <= 1'b0;
      parodd_q <= 1'b0;
`endif
    end else begin
      soft_rst <= wr && address == ADDR_W'(0) && wdata[0];
      if (wr && address == ADDR_W'(1)) div <= wdata[DIV_W-1:0];
      if (wr && address == ADDR_W'(3)) begin
        txen     <= wdata[0];
        rxen     <= wdata[1];
        flowen   <= wdata[2];
`ifdef UART_PARITY_EN
        paren_q  <= wdata[3];
        parodd_q <= wdata[4];
`endif
      end
    end
  end

  // ---------------- FIFOs ----------------
  logic [7:0]        tx_mem [DEPTH_N];
  logic [7:0]        rx_mem [DEPTH_N];
  logic [FIFO_W-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [FIFO_W:0]   tx_level, rx_level;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_push_ok, tx_pop, rx_push_ok, rx_pop, status_rd;
  logic rx_push_q;
  logic [7:0] rx_push_data;

  assign tx_full    = tx_level == DEPTH;
  assign tx_empty   = tx_level == '0;
  assign rx_full    = rx_level == DEPTH;
  assign rx_empty   = rx_level == '0;
  assign tx_push    = wr && address == ADDR_W'(2);
  assign tx_push_ok = tx_push & ~tx_full;
  assign rx_push_ok = rx_push_q & ~rx_full;
  assign rx_pop     = rd && address == ADDR_W'(5) && !rx_empty;
  assign status_rd  = rd && address == ADDR_W'(4);

  // FIFO storage writes.
  // NOTE: FIFO storage has no reset; pointers and levels alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem[tx_wptr] <= wdata[7:0];
    if (rx_push_ok) rx_mem[rx_wptr] <= rx_push_data;
  end

  // FIFO pointers and levels; soft reset flushes both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wptr <= '0; tx_rptr <= '0; tx_level <= '0;
      rx_wptr <= '0; rx_rptr <= '0; rx_level <= '0;
    end else if (soft_rst) begin
      tx_wptr <= '0; tx_rptr <= '0; tx_level <= '0;
      rx_wptr <= '0; rx_rptr <= '0; rx_level <= '0;
    end else begin
      if (tx_push_ok) tx_wptr <= tx_wptr + FIFO_W'(1);
      if (tx_pop)     tx_rptr <= tx_rptr + FIFO_W'(1);
      tx_level <= tx_level + (FIFO_W+1)'(tx_push_ok) - (FIFO_W+1)'(tx_pop);
      if (rx_push_ok) rx_wptr <= rx_wptr + FIFO_W'(1);
      if (rx_pop)     rx_rptr <= rx_rptr + FIFO_W'(1);
      rx_level <= rx_level + (FIFO_W+1)'(rx_push_ok) - (FIFO_W+1)'(rx_pop);
    end
  end

  // ---------------- TX FSM ----------------
  state_t tx_state, tx_state_n;
  logic [DIV_W-1:0] tx_cnt, tx_cnt_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic [7:0] tx_sh, tx_sh_n;
  logic tx_par, tx_par_n, txd_n;

  // TX next state; cts and TXEN are only consulted in IDLE.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + DIV_W'(1);
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_par_n   = tx_par;
    tx_pop     = 1'b0;
    txd_n      = 1'b1;
    case (tx_state)
      S_IDLE: begin
        tx_cnt_n = '0;
        if (txen && !tx_empty && (!flowen || cts)) begin
          tx_state_n = S_START;
          tx_pop     = 1'b1;
          tx_sh_n    = tx_mem[tx_rptr];
          tx_par_n   = (^tx_mem[tx_rptr]) ^ parodd;
        end
      end
      S_START: begin
        txd_n = 1'b0;
        if (tx_cnt >= bit_end) begin
          tx_cnt_n = '0; tx_bit_n = '0; tx_state_n = S_DATA;
        end
      end
      S_DATA: begin
        txd_n = tx_sh[0];
        if (tx_cnt >= bit_end) begin
          tx_cnt_n = '0;
          tx_sh_n  = tx_sh >> 1;
          tx_bit_n = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_n = paren ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        txd_n = tx_par;
        if (tx_cnt >= bit_end) begin tx_cnt_n = '0; tx_state_n = S_STOP; end
      end
      S_STOP: begin
        if (tx_cnt >= bit_end) begin tx_cnt_n = '0; tx_state_n = S_IDLE; end
      end
      default: tx_state_n = S_IDLE;
    endcase
  end

  // TX state register; txd is registered from the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= S_IDLE; tx_cnt <= '0; tx_bit <= '0; tx_sh <= '0; tx_par <= 1'b0; txd <= 1'b1;
    end else if (soft_rst) begin
      tx_state <= S_IDLE; tx_cnt <= '0; tx_bit <= '0; txd <= 1'b1;
    end else begin
      tx_state <= tx_state_n; tx_cnt <= tx_cnt_n; tx_bit <= tx_bit_n;
      tx_sh <= tx_sh_n; tx_par <= tx_par_n; txd <= txd_n;
    end
  end

  // ---------------- RX FSM ----------------
  state_t rx_state, rx_state_n;
  logic [DIV_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_sh, rx_sh_n;
  logic [1:0] rx_sync_ff;
  logic rx_sync, rx_prev, rx_par, rx_par_n;
  logic rx_push_req, rx_frame_set, rx_par_set;
  assign rx_sync = rx_sync_ff[1];

  // RX next state; samples are taken mid-bit, DIV cycles apart.
  always_comb begin
    rx_state_n   = rx_state;
    rx_cnt_n     = rx_cnt + DIV_W'(1);
    rx_bit_n     = rx_bit;
    rx_sh_n      = rx_sh;
    rx_par_n     = rx_par;
    rx_push_req  = 1'b0;
    rx_frame_set = 1'b0;
    rx_par_set   = 1'b0;
    if (!rxen) begin
      rx_state_n = S_IDLE;
      rx_cnt_n   = '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          rx_cnt_n = '0;
          if (rx_prev && !rx_sync) rx_state_n = S_START;
        end
        S_START: begin
          if (rx_cnt >= half_end) begin
            rx_cnt_n = '0; rx_bit_n = '0;
            rx_state_n = rx_sync ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (rx_cnt >= bit_end) begin
            rx_cnt_n = '0;
            rx_sh_n  = {rx_sync, rx_sh[7:1]};
            rx_bit_n = rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state_n = paren ? S_PAR : S_STOP;
          end
        end
        S_PAR: begin
          if (rx_cnt >= bit_end) begin
            rx_cnt_n = '0; rx_par_n = rx_sync; rx_state_n = S_STOP;
          end
        end
        S_STOP: begin
          if (rx_cnt >= bit_end) begin
            rx_cnt_n = '0; rx_state_n = S_IDLE;
            if (!rx_sync) rx_frame_set = 1'b1;
            else if (paren && (rx_par != ((^rx_sh) ^ parodd))) rx_par_set = 1'b1;
            else rx_push_req = 1'b1;
          end
        end
        default: rx_state_n = S_IDLE;
      endcase
    end
  end

  // RX synchronizer, state register and one-cycle push stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync_ff <= 2'b11; rx_prev <= 1'b1;
      rx_state <= S_IDLE; rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0; rx_par <= 1'b0;
      rx_push_q <= 1'b0; rx_push_data <= '0;
    end else begin
      rx_sync_ff <= {rx_sync_ff[0], rxd};
      rx_prev    <= rx_sync;
      if (soft_rst) begin
        rx_state <= S_IDLE; rx_cnt <= '0; rx_bit <= '0; rx_push_q <= 1'b0;
      end else begin
        rx_state <= rx_state_n; rx_cnt <= rx_cnt_n; rx_bit <= rx_bit_n;
        rx_sh <= rx_sh_n; rx_par <= rx_par_n;
        rx_push_q <= rx_push_req;
        if (rx_push_req) rx_push_data <= rx_sh;
      end
    end
  end

  // ---------------- Flags, readback, bus ----------------
  logic tx_ovf, rx_ovr, frame_err, par_err, tx_busy;
  logic [DATA_W-1:0] rd_val;
  assign tx_busy = tx_state != S_IDLE;
  assign rts     = rxen & ~(flowen & (rx_level >= RTS_LVL));

  // Sticky flags: a new event wins over a clearing STATUS read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_ovf <= 1'b0; rx_ovr <= 1'b0; frame_err <= 1'b0; par_err <= 1'b0;
    end else if (soft_rst) begin
      tx_ovf <= 1'b0; rx_ovr <= 1'b0; frame_err <= 1'b0; par_err <= 1'b0;
    end else begin
      tx_ovf    <= (tx_ovf    & ~status_rd) | (tx_push & tx_full);
      rx_ovr    <= (rx_ovr    & ~status_rd) | (rx_push_q & rx_full);
      frame_err <= (frame_err & ~status_rd) | rx_frame_set;
      par_err   <= (par_err   & ~status_rd) | rx_par_set;
    end
  end

  // Read mux; write-only and unmapped registers read as zero.
  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_W'(4): rd_val[8:0] = {tx_busy, par_err, frame_err, rx_ovr, tx_ovf,
                                 rx_full, rx_empty, tx_empty, tx_full};
      ADDR_W'(5): if (!rx_empty) rd_val[8:0] = {1'b1, rx_mem[rx_rptr]};
      ADDR_W'(6): rd_val[FIFO_W:0] = tx_level;
      ADDR_W'(7): rd_val[FIFO_W:0] = rx_level;
      default:    rd_val = '0;
    endcase
  end

  // Registered bus response: ready follows valid by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready <= 1'b0; rdata <= '0;
    end else begin
      ready <= valid;
      rdata <= rd ? rd_val : '0;
    end
  end

endmodule

// File: doc/iob_uart_fifo.md
# iob_uart_fifo

Buffered, parametrised successor to the single-byte UART peripheral: same native CPU slave interface, with TX and RX FIFOs, RTS/CTS flow control, sticky error flags, FIFO level readback and a wider divider. It sits on the system interconnect as a memory-mapped slave and drives the board serial pins. Frames are 8 data bits, LSB first, 1 stop bit, with an optional parity bit.

## Interface
- ADDR_W, 3: word address width (8 registers).
- DATA_W, 32: CPU data width.
- DIV_W, 16: divider width, in clk cycles per bit.
- FIFO_W, 4: log2 of FIFO depth (DEPTH = 2^FIFO_W, applies to both FIFOs).
- clk  in  1  system clock
- rst  in  1  reset, asynchronous and active-high
- valid  in  1  native request valid
- address  in  ADDR_W  word address
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  write strobes; any bit set means write, all zero means read
- rdata  out  DATA_W  read data, registered
- ready  out  1  request acknowledge, registered
- txd  out  1  serial out, idle high
- rxd  in  1  serial in, asynchronous
- cts  in  1  clear-to-send from peer, active-high
- rts  out  1  ready-to-receive to peer, active-high

## Operation
- Register map (W = write, R = read):
  - 0 SOFTRESET W: writing 1 produces a one-cycle pulse. It flushes both FIFOs, returns both FSMs to IDLE, drives txd to 1, clears the sticky flags, and keeps DIV and CTRL.
  - 1 DIV W: bit period. A value below 2 is treated as 2.
  - 2 TXDATA W: pushes wdata[7:0] into the TX FIFO. When the FIFO is full, the byte is dropped and TX_OVF is set.
  - 3 CTRL W: bit0 TXEN, bit1 RXEN, bit2 FLOWEN, bit3 PAREN, bit4 PARODD.
  - 4 STATUS R: bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_full, bit4 TX_OVF, bit5 RX_OVR, bit6 FRAME_ERR, bit7 PAR_ERR, bit8 tx_busy. A read clears bits 4–7.
  - 5 RXDATA R: pops the RX FIFO. Returns {bit8 = 1, byte} when not empty; returns 0 with no pop when empty.
  - 6 TXLEVEL R, 7 RXLEVEL R: occupancy, 0..DEPTH, FIFO_W+1 bits.
- Unmapped and write-only registers read as 0.
- TX FSM states: IDLE → START → DATA(8) → PARITY (only if PAREN) → STOP → IDLE.
  - Leaves IDLE when TXEN & !tx_empty & (!FLOWEN | cts). cts is sampled only in IDLE.
  - Each state lasts DIV cycles.
- RX FSM states: IDLE → START → DATA(8) → PARITY (only if PAREN) → STOP → IDLE.
  - rxd passes through a 2-FF synchronizer, reset value 1.
  - A falling edge while RXEN starts START. The line is checked at DIV/2; if high, it is a false start and the FSM returns to IDLE.
  - Each later bit is sampled DIV cycles apart.
  - STOP sampled low: set FRAME_ERR and discard the byte. Parity mismatch: set PAR_ERR and discard the byte.
  - Otherwise push the byte. If the FIFO is full, drop the byte and set RX_OVR.
- rts = RXEN & !(FLOWEN & RXLEVEL ≥ DEPTH−2).
- Parity: even means data XOR = parity bit. PARODD inverts this.
- Full/empty is judged on the level at the start of the cycle. A pop and a push in the same cycle are both performed, but a push into a full FIFO is still dropped. Pointers wrap modulo DEPTH.
- Clearing TXEN mid-frame completes the current frame and starts no new one. Clearing RXEN mid-frame aborts reception and sends RX to IDLE.

## Timing
- Reset values:
  - Outputs: txd=1, rts=0, ready=0, rdata=0.
  - Registers: DIV=0, so the bit period is 2. CTRL=0. FIFOs empty. Flags clear.
- ready = valid delayed one cycle. rdata is valid in the ready cycle.
- Register writes and FIFO push/pop take effect at the edge that samples valid.
- TX start: txd falls 2 edges after the accepted TXDATA write when TX is IDLE and enabled.
- Frame length: DIV×10 cycles, or DIV×11 with parity.
- RX push: the byte reaches the FIFO 1 cycle after the STOP-bit sample.
- Soft reset: takes effect at the edge after the write edge. A frame in progress is aborted, with txd high on the next cycle.
- Async rst mid-frame: all state goes to its reset value immediately.

## Configuration
- UART_PARITY_EN defined: PARITY states, CTRL bits 3–4 and STATUS bit 7 are implemented.
- Not defined: CTRL bits 3–4 are ignored, STATUS bit 7 reads 0, and frames are always 10 bits.

## Test plan
- Reset, then read every register: all read 0 except STATUS = 0x006 (tx_empty, rx_empty). txd=1, rts=0.
- DIV=4, CTRL=0x3, txd looped to rxd, write 0xA5, 0x3C. Expect txd low for 4 cycles starting 2 edges after the first write. Two RXDATA reads then return 0x1A5 and 0x13C, and STATUS bits 4–7 are 0.
- Fill the TX FIFO with TXEN=0 using DEPTH+1 writes. Expect TXLEVEL=DEPTH, tx_full, TX_OVF. A STATUS read clears TX_OVF.
- FLOWEN=1, cts=0, one byte queued: txd stays 1. Raise cts: the frame starts. With RXLEVEL=DEPTH−2, rts goes to 0.
- Drive rxd with a stop bit of 0: byte discarded, FRAME_ERR=1. Drive a 2-cycle low glitch with DIV=8: no byte received.
- With UART_PARITY_EN, PAREN=1, PARODD=1, loopback 0x01: parity bit is 0 and the byte is received. Inject the wrong parity bit: PAR_ERR=1 and RXLEVEL unchanged.
